// File: rtl/udp_csr_pkg.sv
// Shared offsets, addresses, responses and decode helper for the UDP CSR bank.
// UDP_CSR_IRQ_EN adds decode of the IRQ_EN / IRQ_STAT registers.
package udp_csr_pkg;

  localparam logic [1:0] OFF_DST_IP  = 2'd0;
  localparam logic [1:0] OFF_PORTS   = 2'd1;
  localparam logic [1:0] OFF_PAYLOAD = 2'd2;
  localparam logic [1:0] OFF_LEN     = 2'd3;

  localparam logic [31:0] ADDR_STATUS   = 32'h800;
  localparam logic [31:0] ADDR_IRQ_EN   = 32'h804;
  localparam logic [31:0] ADDR_IRQ_STAT = 32'h808;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    TGT_NONE,
    TGT_CHAN,
    TGT_STATUS,
    TGT_IRQ_EN,
    TGT_IRQ_STAT
  } tgt_e;

  typedef struct packed {
    tgt_e       tgt;
    logic [4:0] ch;
    logic [1:0] sel;
  } dec_t;

  // wa is the word address (byte address >> 2)
  function automatic dec_t csr_decode(
    input logic [29:0] wa,
    input int          nch
  );
    dec_t d;
    d.tgt = TGT_NONE;
    d.ch  = wa[6:2];
    d.sel = wa[1:0];
    unique case (1'b1)
      (32'(wa[29:2]) < nch):      d.tgt = TGT_CHAN;
      (wa == ADDR_STATUS[31:2]):  d.tgt = TGT_STATUS;
`ifdef UDP_CSR_IRQ_EN
      (wa == ADDR_IRQ_EN[31:2]):  d.tgt = TGT_IRQ_EN;
      (wa == ADDR_IRQ_STAT[31:2]): d.tgt = TGT_IRQ_STAT;
`endif
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/axil_udp_csr_bank_if.sv
// AXI4-Lite slave bus bundle for the UDP CSR bank.
// Master drives requests; slave drives ready/response signals.
interface axil_udp_csr_bank_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] s_awaddr;
  logic              s_awvalid;
  logic              s_awready;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic              s_wvalid;
  logic              s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready;
  logic [ADDR_W-1:0] s_araddr;
  logic              s_arvalid;
  logic              s_arready;
  logic [31:0]       s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid;
  logic              s_rready;

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid,
    output s_bready, s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid,
    input  s_arready, s_rdata, s_rresp, s_rvalid
  );

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid,
    input  s_bready, s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid,
    output s_arready, s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/udp_csr_chan.sv
// One UDP descriptor channel: four registers, byte merge, written mask,
// and the valid/ready hand-off to the UDP engine.
module udp_csr_chan
  import udp_csr_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [1:0]   wr_sel,
  input  logic [31:0]  wr_data,
  input  logic [3:0]   wr_strb,
  input  logic         ready,
  output logic [127:0] desc,
  output logic         valid
);

  logic [3:0][31:0] regs;
  logic [3:0]       mask;
  logic [31:0]      merged;
  logic             wr_ok;

  assign wr_ok = wr_en && !valid && (wr_strb != 4'h0);

  always_comb begin
    merged = regs[wr_sel];
    for (int b = 0; b < 4; b++) begin
      if (wr_strb[b]) merged[8*b +: 8] = wr_data[8*b +: 8];
    end
  end

  // A full mask hands the descriptor over one edge later
  always_ff @(posedge clk) begin
    if (rst) begin
      regs  <= '0;
      mask  <= '0;
      valid <= 1'b0;
    end else begin
      if (valid && ready) valid <= 1'b0;
      if (mask == 4'hF) begin
        valid <= 1'b1;
        mask  <= '0;
      end else if (wr_ok) begin
        regs[wr_sel] <= merged;
        mask[wr_sel] <= 1'b1;
      end
    end
  end

  assign desc = {regs[OFF_LEN], regs[OFF_PAYLOAD],
                 regs[OFF_PORTS], regs[OFF_DST_IP]};

endmodule

// File: rtl/axil_udp_csr_bank.sv
// AXI4-Lite CSR bank feeding per-channel UDP descriptors to the engine.
// Define UDP_CSR_IRQ_EN to add irq with IRQ_EN (0x804) / IRQ_STAT (0x808).
module axil_udp_csr_bank
  import udp_csr_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int ADDR_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  axil_udp_csr_bank_if.slave axil,
  output logic [NCH*128-1:0] ch_desc,
  output logic [NCH-1:0]     ch_valid,
  input  logic [NCH-1:0]     ch_ready
`ifdef UDP_CSR_IRQ_EN
  ,
  output logic               irq
`endif
);

  logic              aw_full;
  logic              w_full;
  logic [ADDR_W-3:0] aw_waddr;
  logic [31:0]       w_data;
  logic [3:0]        w_strb;
  logic              bvalid_q;
  logic [1:0]        bresp_q;
  logic              rvalid_q;
  logic [31:0]       rdata_q;
  logic [1:0]        rresp_q;
  logic              commit;
  dec_t              wdec;
  dec_t              rdec;
  logic              wr_busy;
  logic [1:0]        wr_resp;
  logic [NCH-1:0]    ch_wr;
  logic [127:0]      rd_chan;
  logic [31:0]       rd_data;
  logic [1:0]        rd_resp;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^{axil.s_awaddr[1:0], axil.s_araddr[1:0]};

  assign axil.s_awready = !aw_full;
  assign axil.s_wready  = !w_full;
  assign axil.s_bvalid  = bvalid_q;
  assign axil.s_bresp   = bresp_q;
  assign axil.s_arready = !rvalid_q;
  assign axil.s_rvalid  = rvalid_q;
  assign axil.s_rdata   = rdata_q;
  assign axil.s_rresp   = rresp_q;

  assign commit = aw_full && w_full && !bvalid_q;
  assign wdec   = csr_decode(30'(aw_waddr), NCH);
  assign rdec   = csr_decode(30'(axil.s_araddr[ADDR_W-1:2]), NCH);

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      aw_waddr <= '0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      if (axil.s_awvalid && !aw_full) begin
        aw_full  <= 1'b1;
        aw_waddr <= axil.s_awaddr[ADDR_W-1:2];
      end else if (commit) begin
        aw_full <= 1'b0;
      end
      if (axil.s_wvalid && !w_full) begin
        w_full <= 1'b1;
        w_data <= axil.s_wdata;
        w_strb <= axil.s_wstrb;
      end else if (commit) begin
        w_full <= 1'b0;
      end
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_resp;
      end else if (bvalid_q && axil.s_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    wr_busy = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (wdec.ch == 5'(c)) wr_busy = ch_valid[c];
    end
  end

  // A channel owned by the engine rejects writes until it is consumed
  always_comb begin
    wr_resp = RESP_SLVERR;
    ch_wr   = '0;
    unique case (wdec.tgt)
      TGT_CHAN: begin
        if (!wr_busy) begin
          wr_resp = RESP_OKAY;
          for (int c = 0; c < NCH; c++) begin
            ch_wr[c] = commit && (wdec.ch == 5'(c));
          end
        end
      end
`ifdef UDP_CSR_IRQ_EN
      TGT_IRQ_EN:   wr_resp = RESP_OKAY;
      TGT_IRQ_STAT: wr_resp = RESP_OKAY;
`endif
      default: ;
    endcase
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    udp_csr_chan u_chan (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (ch_wr[c]),
      .wr_sel  (wdec.sel),
      .wr_data (w_data),
      .wr_strb (w_strb),
      .ready   (ch_ready[c]),
      .desc    (ch_desc[c*128 +: 128]),
      .valid   (ch_valid[c])
    );
  end

`ifdef UDP_CSR_IRQ_EN
  logic irq_en;
  logic irq_stat;
  logic consume;

  assign consume = |(ch_valid & ch_ready);

  // A consume in the same cycle as the clear wins, so no event is lost
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en   <= 1'b0;
      irq_stat <= 1'b0;
    end else begin
      if (commit && wdec.tgt == TGT_IRQ_EN && w_strb[0]) begin
        irq_en <= w_data[0];
      end
      if (consume) begin
        irq_stat <= 1'b1;
      end else if (commit && wdec.tgt == TGT_IRQ_STAT &&
                   w_strb[0] && w_data[0]) begin
        irq_stat <= 1'b0;
      end
    end
  end

  assign irq = irq_en & irq_stat;
`endif

  always_comb begin
    rd_chan = '0;
    for (int c = 0; c < NCH; c++) begin
      if (rdec.ch == 5'(c)) rd_chan = ch_desc[c*128 +: 128];
    end
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_SLVERR;
    unique case (rdec.tgt)
      TGT_CHAN: begin
        rd_data = rd_chan[{rdec.sel, 5'b0} +: 32];
        rd_resp = RESP_OKAY;
      end
      TGT_STATUS: begin
        rd_data = 32'(ch_valid);
        rd_resp = RESP_OKAY;
      end
`ifdef UDP_CSR_IRQ_EN
      TGT_IRQ_EN: begin
        rd_data = {31'b0, irq_en};
        rd_resp = RESP_OKAY;
      end
      TGT_IRQ_STAT: begin
        rd_data = {31'b0, irq_stat};
        rd_resp = RESP_OKAY;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      if (axil.s_arvalid && !rvalid_q) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_resp;
      end else if (rvalid_q && axil.s_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/axil_udp_csr_bank.md
AXIL_UDP_CSR_BANK -- requirements
Module: axil_udp_csr_bank

Interface
REQ-001 SHALL have parameter NCH, default 4: number of UDP descriptor channels, legal 1..32.
REQ-002 SHALL have parameter ADDR_W, default 12: AXI4-Lite address width actually decoded.
REQ-003 SHALL have port clk  in  1  clock; all logic on the rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port s_awaddr  in  ADDR_W  write address.
REQ-006 SHALL have port s_awvalid  in  1  write address valid.
REQ-007 SHALL have port s_awready  out  1  write address ready.
REQ-008 SHALL have port s_wdata  in  32  write data.
REQ-009 SHALL have port s_wstrb  in  4  write byte strobes.
REQ-010 SHALL have port s_wvalid  in  1  write data valid.
REQ-011 SHALL have port s_wready  out  1  write data ready.
REQ-012 SHALL have port s_bresp  out  2  write response.
REQ-013 SHALL have port s_bvalid  out  1  write response valid.
REQ-014 SHALL have port s_bready  in  1  master accepts the write response.
REQ-015 SHALL have port s_araddr  in  ADDR_W  read address.
REQ-016 SHALL have port s_arvalid  in  1  read address valid.
REQ-017 SHALL have port s_arready  out  1  read address ready.
REQ-018 SHALL have port s_rdata  out  32  read data.
REQ-019 SHALL have port s_rresp  out  2  read response.
REQ-020 SHALL have port s_rvalid  out  1  read data valid.
REQ-021 SHALL have port s_rready  in  1  master accepts the read data.
REQ-022 SHALL have port ch_desc  out  NCH*128  per channel {len, payload, ports, dst_ip}; channel c occupies bits [128c+127:128c].
REQ-023 SHALL have port ch_valid  out  NCH  channel c descriptor complete and awaiting the UDP engine.
REQ-024 SHALL have port ch_ready  in  NCH  UDP engine consumes channel c.
REQ-025 SHALL have port irq  out  1  present only with UDP_CSR_IRQ_EN.

Function
REQ-026 SHALL use this address map on addr[ADDR_W-1:2]: channel c at c*0x10; +0x0 dst_ip, +0x4 ports {src[31:16], dst[15:0]}, +0x8 payload, +0xC len; STATUS at 0x800 (read-only, bit c = ch_valid[c]); every other address is unmapped.
REQ-027 SHALL accept AW and W independently, each into a one-deep holding register; awready/wready are high while that holder is empty; no combinational path from valid to ready.
REQ-028 SHALL commit a write in the cycle both holders are full and bvalid is low, then assert bvalid on the next cycle and hold it, with bresp stable, until bready; both holders are freed at commit.
REQ-029 SHALL update only the bytes whose wstrb bit is set; wstrb=0 is a legal no-op returning OKAY.
REQ-030 SHALL keep a 4-bit written mask per channel; ch_valid[c] rises the cycle after the mask reaches 4'hF, and the mask clears in the same edge.
REQ-031 SHALL drop ch_valid[c] on the edge where ch_valid[c] and ch_ready[c] are both high; the descriptor contents remain unchanged.
REQ-032 SHALL reject a write to channel c while ch_valid[c]=1 with bresp SLVERR (2'b10), leaving its registers and mask unchanged; unmapped writes and writes to STATUS also return SLVERR.
REQ-033 SHALL raise arready when rvalid is low; rvalid rises on the edge after the AR handshake and holds until rready; rdata is registered; unmapped reads return 0 with SLVERR.
REQ-034 SHALL let a consume on ch_ready, arriving in the same cycle as a rejected write, take effect so that the write still returns SLVERR; the writer retries.

Reset
REQ-035 SHALL, on reset, drive awready=wready=arready=1, bvalid=rvalid=0, bresp=rresp=0, rdata=0, ch_desc=0, ch_valid=0, irq=0, and clear all masks and holders; an in-flight transaction is discarded without a response.

Configuration
REQ-036 SHALL, when macro UDP_CSR_IRQ_EN is defined, add irq plus an IRQ_EN register at 0x804 (bit 0) and IRQ_STAT at 0x808 (bit 0, write-1-to-clear); IRQ_STAT sets the cycle after any ch_valid falling edge, and irq = IRQ_STAT & IRQ_EN; without the macro, the port and registers are absent and 0x804/0x808 decode as unmapped.

Structure
REQ-037 SHALL place register offsets, the STATUS/IRQ addresses and RESP_OKAY/RESP_SLVERR in the shared package udp_csr_pkg.
REQ-038 SHALL instantiate one sub-module udp_csr_chan per channel (registers, byte-strobe merge, mask, valid/ready); the AXI handshake logic and decode live in the top level.

Verification
REQ-039 Write 0xC0A80001, 0x1F901F91, 0xDEADBEEF, 0x00000004 to 0x010..0x01C -> ch_valid[1]=1 one cycle after the last B; ch_desc[255:128]=0x00000004_DEADBEEF_1F901F91_C0A80001.
REQ-040 AW issued 3 cycles before W to 0x000, wstrb=4'b0011, data 0xAABBCCDD, prior value 0x11223344 -> one B, OKAY; register reads back 0x1122CCDD.
REQ-041 With ch_valid[0]=1, write to 0x004 -> bresp SLVERR and register unchanged; pulse ch_ready[0], retry -> OKAY.
REQ-042 Read 0x800 with channels 0 and 2 valid -> rdata=0x5, OKAY; read 0x7F0 -> rdata=0, SLVERR; rready held low for 5 cycles -> rvalid and rdata stable throughout.
REQ-043 With UDP_CSR_IRQ_EN and IRQ_EN=1, consume channel 3 -> irq=1 the next cycle; write 1 to 0x808 -> irq=0.
